gmii_frame_tx: RTL and testbench
================================

Name: gmii_frame_tx

Overview:
Ethernet transmit framer on the GMII side of the TX path; it is the counterpart of the RGMII/GMII receive path.
- Accepts payload bytes (destination MAC through end of payload) over a valid/ready/last stream.
- Emits a complete GMII frame: preamble, SFD, payload, zero-pad to minimum length, CRC-32 FCS, then enforces the inter-frame gap.
- Output feeds the RGMII DDR output stage, which runs on the same clock.

Parameters:
IFG_BYTES, 12, idle cycles (tx_en low) enforced after each frame, legal 1..63
PAD_EN, 1, 1 = zero-pad payload+pad to 60 bytes before FCS; 0 = no padding
MIN_LEN, 60, minimum payload+pad byte count when PAD_EN=1

Ports:
gmii_tx_clk  input  1  125 MHz GMII transmit clock; sole clock
rst          input  1  synchronous reset, active-high
s_data       input  8  payload byte
s_valid      input  1  s_data valid
s_last       input  1  marks final payload byte, qualified by s_valid
s_ready      output 1  byte accepted when s_valid & s_ready
gmii_tx_en   output 1  GMII transmit enable
gmii_tx_er   output 1  GMII transmit error
gmii_txd     output 8  GMII transmit data
tx_done      output 1  1-cycle pulse in cycle after last FCS byte
tx_abort     output 1  1-cycle pulse coincident with error byte

Behaviour:
Reset and register rules:
- All outputs are registered, except s_ready, which is combinational from state.
- Reset sets all outputs to 0 and state to IDLE.
- Reset mid-frame: tx_en drops the next cycle, no FCS is sent, CRC and counters clear.
- State names what is on gmii_txd this cycle.

States:
- IDLE: en=0, txd=0x00, s_ready=0. If s_valid: -> PRE (no byte consumed).
- PRE: txd=0x55, en=1, 7 cycles -> SFD.
- SFD: txd=0xD5, en=1, s_ready=1 -> DATA on accept.
- DATA: txd = byte accepted last cycle; s_ready=1 until s_last accepted.
  - Byte counter increments per byte and saturates at 2047.
  - CRC updates per byte.
- After s_last is accepted: if PAD_EN and count < MIN_LEN -> PAD, else -> FCS.
- PAD: txd=0x00, CRC updated, until count == MIN_LEN -> FCS.
- FCS: 4 cycles emitting ~crc, LSB byte first.
  - CRC-32 is reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - After the 4th byte -> IFG, with tx_done pulse.
- IFG: en=0, txd=0x00, IFG_BYTES cycles.
  - At end: s_valid ? -> PRE : -> IDLE.
  - Back-to-back gap is exactly IFG_BYTES cycles.
- Underrun: s_ready=1 in SFD/DATA while s_valid=0.
  - Next cycle -> ERR: txd=0x00, en=1, er=1, tx_abort=1, one cycle.
  - Then -> FLUSH, or -> IFG if s_last was already accepted.
- FLUSH: en=0, s_ready=1, discards bytes until s_last accepted -> IFG.

Latency: s_valid rising in IDLE at cycle k gives:
- tx_en high at k+1
- SFD at k+8 (s_ready high)
- first payload byte on txd at k+9

gmii_tx_er=0 in every state except ERR.

Test Plan:
1. PAD_EN=0, payload ASCII "123456789" (0x31..0x39) -> 0x55×7, 0xD5, 9 payload bytes, FCS 0x26,0x39,0xF4,0xCB; tx_done one cycle after 0xCB; 12 idle cycles.
2. PAD_EN=1, 14-byte payload -> 46 bytes of 0x00 follow payload; FCS computed over 60 bytes matches reference CRC model; tx_en high for 72 cycles total.
3. Two 64-byte frames with s_valid held high -> exactly IFG_BYTES=12 cycles of en=0 between frames; second preamble starts immediately after.
4. Drop s_valid for 1 cycle at payload byte 20 (s_last at byte 40) -> error byte: en=1, er=1, tx_abort pulse; then en=0; bytes 21..40 consumed with no output; no tx_done; next frame follows after 12 idle cycles.
5. Assert rst during FCS byte 2 -> next cycle en=0, txd=0, s_ready=0; new frame afterward produces correct CRC (no residue).
6. Single-byte payload with PAD_EN=1 and s_last on the first byte -> 1 data + 59 pad bytes; s_ready low from the cycle after accept until the next frame's SFD.

Source files
------------

// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: wraps a valid/ready/last payload stream in preamble,
// SFD, optional zero padding and a CRC-32 FCS, then holds the inter-frame gap.
// Every GMII-side output is registered; s_ready is decoded from state.
//
// state   | meaning (what is on gmii_txd this cycle)
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for s_valid
// S_PRE   | preamble byte 0x55 (7 cycles)
// S_SFD   | start-of-frame delimiter 0xD5, first payload byte may be taken
// S_DATA  | payload byte accepted in the previous cycle
// S_PAD   | zero pad byte up to MIN_LEN
// S_FCS   | one of the four FCS bytes, LSB first
// S_ERR   | error byte (tx_er high) after a payload underrun
// S_FLUSH | line idle, discarding the rest of the aborted frame
// S_IFG   | inter-frame gap, IFG_BYTES cycles
module gmii_frame_tx #(
  parameter int IFG_BYTES = 12,
  parameter bit PAD_EN    = 1'b1,
  parameter int MIN_LEN   = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       tx_done,
  output logic       tx_abort
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_ERR,
    S_FLUSH,
    S_IFG
  } state_t;

  localparam logic [5:0]  PRE_LOAD  = 6'd6;
  localparam logic [5:0]  FCS_LOAD  = 6'd3;
  localparam logic [5:0]  IFG_LOAD  = 6'(IFG_BYTES - 1);
  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

  state_t      state;
  logic [5:0]  tmr;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc;
  logic        last_seen;

  // Reflected CRC-32 (poly 0x04C11DB7, reversed form 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Payload is only taken while the SFD or an unfinished DATA phase is on the line,
  // or while an aborted frame is being flushed.
  always_comb begin
    s_ready = (state == S_SFD) || ((state == S_DATA) && !last_seen) || (state == S_FLUSH);
  end

  // Byte counter saturates so very long frames cannot wrap into the pad decision.
  always_comb begin
    byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
  end

  // Framer FSM: next state and the registered line outputs that belong to it.
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      tmr        <= 6'd0;
      byte_cnt   <= 11'd0;
      crc        <= 32'hFFFF_FFFF;
      last_seen  <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            state      <= S_PRE;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
            tmr        <= PRE_LOAD;
            crc        <= 32'hFFFF_FFFF;
            byte_cnt   <= 11'd0;
            last_seen  <= 1'b0;
          end
        end

        S_PRE: begin
          if (tmr == 6'd0) begin
            state    <= S_SFD;
            gmii_txd <= 8'hD5;
          end else begin
            tmr <= tmr - 6'd1;
          end
        end

        S_SFD, S_DATA: begin
          if ((state == S_DATA) && last_seen) begin
            if (PAD_EN && (byte_cnt < MIN_LEN_C)) begin
              state    <= S_PAD;
              gmii_txd <= 8'h00;
              crc      <= crc_next(crc, 8'h00);
              byte_cnt <= byte_cnt_inc;
            end else begin
              state    <= S_FCS;
              gmii_txd <= ~crc[7:0];
              tmr      <= FCS_LOAD;
            end
          end else if (s_valid) begin
            state     <= S_DATA;
            gmii_txd  <= s_data;
            crc       <= crc_next(crc, s_data);
            byte_cnt  <= byte_cnt_inc;
            last_seen <= s_last;
          end else begin
            // Source starved us mid-frame: poison the frame on the wire.
            state      <= S_ERR;
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            tx_abort   <= 1'b1;
          end
        end

        S_PAD: begin
          if (byte_cnt >= MIN_LEN_C) begin
            state    <= S_FCS;
            gmii_txd <= ~crc[7:0];
            tmr      <= FCS_LOAD;
          end else begin
            gmii_txd <= 8'h00;
            crc      <= crc_next(crc, 8'h00);
            byte_cnt <= byte_cnt_inc;
          end
        end

        S_FCS: begin
          // crc shifts right one byte per FCS cycle so the next byte is always at [15:8].
          if (tmr == 6'd0) begin
            state      <= S_IFG;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_done    <= 1'b1;
            tmr        <= IFG_LOAD;
          end else begin
            gmii_txd <= ~crc[15:8];
            crc      <= crc >> 8;
            tmr      <= tmr - 6'd1;
          end
        end

        S_ERR: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (last_seen) begin
            state <= S_IFG;
            tmr   <= IFG_LOAD;
          end else begin
            state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (s_valid && s_last) begin
            state <= S_IFG;
            tmr   <= IFG_LOAD;
          end
        end

        S_IFG: begin
          if (tmr == 6'd0) begin
            if (s_valid) begin
              state      <= S_PRE;
              gmii_tx_en <= 1'b1;
              gmii_txd   <= 8'h55;
              tmr        <= PRE_LOAD;
              crc        <= 32'hFFFF_FFFF;
              byte_cnt   <= 11'd0;
              last_seen  <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tmr <= tmr - 6'd1;
          end
        end

        default: begin
          state      <= S_IDLE;
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Scoreboard bench for gmii_frame_tx: instance 0 pads (PAD_EN=1), instance 1 does not.
// The driver pushes every expected line byte (plus tx_done markers and gap
// expectations) into queues; per-instance monitors pop and compare.
module tb_gmii_frame_tx;

  localparam int IFG  = 12;
  localparam int MINL = 60;
  localparam int WAIT_LIMIT = 3000;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst;
  logic       s_valid_w  [2];
  logic       s_last_w   [2];
  logic [7:0] s_data_w   [2];
  logic       s_ready_w  [2];
  logic       tx_en_w    [2];
  logic       tx_er_w    [2];
  logic [7:0] txd_w      [2];
  logic       tx_done_w  [2];
  logic       tx_abort_w [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  // token: [10] tx_done, [9] s_ready, [8] tx_er, [7:0] txd
  logic [10:0] exp_q [$];
  int          gap_val_q [$];
  bit          gap_exact_q [$];

  logic [7:0]  pay [0:255];
  logic [31:0] crc_tab [0:255];
  bit          fcs_fix = 1'b0;
  logic [31:0] fcs_val = 32'h0;
  int          prev_kind [2];
  int          prev_rem  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gmii_frame_tx #(
      .IFG_BYTES(IFG),
      .PAD_EN   (g == 0),
      .MIN_LEN  (MINL)
    ) u_dut (
      .gmii_tx_clk(clk),
      .rst        (rst),
      .s_data     (s_data_w[g]),
      .s_valid    (s_valid_w[g]),
      .s_last     (s_last_w[g]),
      .s_ready    (s_ready_w[g]),
      .gmii_tx_en (tx_en_w[g]),
      .gmii_tx_er (tx_er_w[g]),
      .gmii_txd   (txd_w[g]),
      .tx_done    (tx_done_w[g]),
      .tx_abort   (tx_abort_w[g])
    );

    int gap_cnt  = 1000;
    bit prev_en  = 1'b0;
    bit in_flush = 1'b0;

    always @(negedge clk) begin
      logic [10:0] act_t;
      logic [10:0] exp_t;
      int          gv;
      bit          gx;
      if (mon_on) begin
        act_t = {tx_done_w[g], s_ready_w[g], tx_er_w[g], txd_w[g]};
        if (tx_en_w[g]) begin
          if (!prev_en) begin
            if (gap_val_q.size() == 0) begin
              fail_unexp("frame_start_unexpected", act_t);
            end else begin
              gv = gap_val_q.pop_front();
              gx = gap_exact_q.pop_front();
              if (gx) check("ifg_exact", gap_cnt, gv);
              else    check("ifg_min", 32'(gap_cnt >= gv), 1);
            end
          end
          if (exp_q.size() == 0) begin
            fail_unexp("line_byte_unexpected", act_t);
          end else begin
            exp_t = exp_q.pop_front();
            check($sformatf("line_byte_u%0d", g), act_t, exp_t);
            if (exp_t[8]) in_flush = 1'b1;
          end
          check("abort_vs_er", tx_abort_w[g], tx_er_w[g]);
          gap_cnt = 0;
        end else begin
          gap_cnt++;
          if (tx_done_w[g]) begin
            if (exp_q.size() == 0) begin
              fail_unexp("tx_done_unexpected", act_t);
            end else begin
              exp_t = exp_q.pop_front();
              check($sformatf("tx_done_u%0d", g), act_t, exp_t);
            end
          end else begin
            check($sformatf("idle_line_u%0d", g),
                  {s_ready_w[g], tx_er_w[g], tx_abort_w[g], txd_w[g]},
                  {in_flush, 1'b0, 1'b0, 8'h00});
          end
          if (in_flush && s_valid_w[g] && s_ready_w[g] && s_last_w[g]) in_flush = 1'b0;
        end
        if (rst) in_flush = 1'b0;
        prev_en = tx_en_w[g];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual 0x%0h required nothing at %0t", name, act, $time);
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic tb_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required completion within %0d cycles", name, WAIT_LIMIT);
    finish_tb();
  endtask

  function automatic logic [10:0] tok(input logic r, input logic e, input logic [7:0] d);
    return {1'b0, r, e, d};
  endfunction

  // Byte-wise table form of the Ethernet CRC, used only by the reference model.
  task automatic build_tab();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  function automatic logic [31:0] ref_fcs(input int len, input int total);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? pay[i] : 8'h00;
      c = crc_tab[(c[7:0] ^ b)] ^ (c >> 8);
    end
    return ~c;
  endfunction

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
  endtask

  task automatic wait_accept(input int g);
    int n;
    bit r;
    n = 0;
    do begin
      @(negedge clk);
      r = s_ready_w[g];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < WAIT_LIMIT);
    if (!r) tb_timeout("s_ready_wait");
  endtask

  // Reference model: expected line bytes for one frame, derived from framing rules.
  task automatic push_frame(input int g, input int len, input int drop, input bit rst_mode);
    int          total;
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) exp_q.push_back(tok(1'b0, 1'b0, 8'h55));
    exp_q.push_back(tok(1'b1, 1'b0, 8'hD5));
    if (drop > 0) begin
      for (int i = 0; i < drop; i++) exp_q.push_back(tok(1'b1, 1'b0, pay[i]));
      exp_q.push_back(tok(1'b0, 1'b1, 8'h00));
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back(tok(i != len - 1, 1'b0, pay[i]));
      total = (g == 0 && len < MINL) ? MINL : len;
      for (int i = len; i < total; i++) exp_q.push_back(tok(1'b0, 1'b0, 8'h00));
      fcs = fcs_fix ? fcs_val : ref_fcs(len, total);
      for (int k = 0; k < (rst_mode ? 3 : 4); k++) exp_q.push_back(tok(1'b0, 1'b0, fcs[8*k +: 8]));
      if (!rst_mode) exp_q.push_back(11'h400);
    end
    fcs_fix = 1'b0;
  endtask

  task automatic send_frame(input int g, input int len, input int drop, input int delay,
                            input bit rst_mode);
    int n;
    if (prev_kind[g] == 0) begin
      gap_val_q.push_back(0);        gap_exact_q.push_back(1'b0);
    end else if (delay > 0) begin
      gap_val_q.push_back(IFG);      gap_exact_q.push_back(1'b0);
    end else if (prev_kind[g] == 1) begin
      gap_val_q.push_back(IFG);      gap_exact_q.push_back(1'b1);
    end else begin
      gap_val_q.push_back(prev_rem[g] + IFG); gap_exact_q.push_back(1'b1);
    end
    push_frame(g, len, drop, rst_mode);

    for (int i = 0; i < delay; i++) begin
      s_valid_w[g] = 1'b0;
      s_last_w[g]  = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < len; i++) begin
      if (drop > 0 && i == drop) begin
        s_valid_w[g] = 1'b0;
        s_last_w[g]  = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid_w[g] = 1'b1;
      s_data_w[g]  = pay[i];
      s_last_w[g]  = (i == len - 1);
      wait_accept(g);
    end
    s_valid_w[g] = 1'b0;
    s_last_w[g]  = 1'b0;
    prev_kind[g] = (drop > 0) ? 2 : 1;
    prev_rem[g]  = len - drop;

    if (rst_mode) begin
      n = 0;
      while (exp_q.size() != 1 && n < WAIT_LIMIT) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (exp_q.size() != 1) tb_timeout("reach_fcs2");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_reset_line", {tx_en_w[g], tx_er_w[g], s_ready_w[g], txd_w[g]}, 11'h000);
      prev_kind[0] = 0;
      prev_kind[1] = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) tb_timeout("drain");
    repeat (IFG + 8) @(posedge clk);
    #1;
    prev_kind[0] = 0;
    prev_kind[1] = 0;
  endtask

  initial begin
    build_tab();
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      s_valid_w[g] = 1'b0;
      s_last_w[g]  = 1'b0;
      s_data_w[g]  = 8'h00;
      prev_kind[g] = 0;
      prev_rem[g]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("reset_outputs",
            {tx_en_w[g], tx_er_w[g], tx_done_w[g], tx_abort_w[g], s_ready_w[g], txd_w[g]},
            13'h0000);
    end
    rst    = 1'b0;
    mon_on = 1'b1;

    // "123456789" without padding, FCS checked against the well-known constant.
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    fcs_fix = 1'b1;
    fcs_val = 32'hCBF4_3926;
    send_frame(1, 9, 0, 0, 1'b0);
    fill(20);
    send_frame(1, 20, 0, 0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      int len;
      len = $urandom_range(1, 80);
      fill(len);
      send_frame(1, len, 0, (f == 2) ? 5 : 0, 1'b0);
    end
    drain();

    // Padded short frame, then two back-to-back 64-byte frames.
    fill(14);
    send_frame(0, 14, 0, 0, 1'b0);
    fill(64);
    send_frame(0, 64, 0, 0, 1'b0);
    fill(64);
    send_frame(0, 64, 0, 0, 1'b0);
    // Underrun at byte 21 of 40, followed immediately by another frame.
    fill(40);
    send_frame(0, 40, 20, 0, 1'b0);
    fill(30);
    send_frame(0, 30, 0, 0, 1'b0);
    // Single byte padded to 60.
    fill(1);
    send_frame(0, 1, 0, 0, 1'b0);
    fill(25);
    send_frame(0, 25, 0, 0, 1'b0);
    drain();

    // Reset during the third FCS byte, then a clean frame.
    fill(64);
    send_frame(0, 64, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    fill(30);
    send_frame(0, 30, 0, 0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      int len;
      int drop;
      int delay;
      len  = $urandom_range(1, 120);
      drop = 0;
      if (len >= 2 && $urandom_range(0, 5) == 0) drop = $urandom_range(1, len - 1);
      delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      fill(len);
      send_frame(0, len, drop, delay, 1'b0);
    end
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    check("gap_queue_empty", gap_val_q.size(), 0);
    finish_tb();
  end

endmodule
